// File: rtl/alu_result_buffer_pkg.sv
// Shared constants for the ALU result buffer: status flag bit positions
// and the 4-bit branch condition codes.
package alu_result_buffer_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_HI = 4'd9,
        COND_LS = 4'd10,
        COND_GE = 4'd11,
        COND_LT = 4'd12,
        COND_GT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

endpackage

// File: rtl/alu_result_buffer_cond_eval.sv
// Purely combinational branch condition evaluator: {N,Z,V,C} + condition
// code -> taken. Shared with the branch unit.
module alu_result_buffer_cond_eval
    import alu_result_buffer_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_condTrue
);

    logic w_n;
    logic w_z;
    logic w_v;
    logic w_c;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];
    assign w_c = i_flags[FLAG_C];

    // Decode the condition code against the current flag bits.
    always_comb begin
        o_condTrue = 1'b0;
        case (cond_e'(i_cond))
            COND_AL: o_condTrue = 1'b1;
            COND_EQ: o_condTrue = w_z;
            COND_NE: o_condTrue = ~w_z;
            COND_CS: o_condTrue = w_c;
            COND_CC: o_condTrue = ~w_c;
            COND_MI: o_condTrue = w_n;
            COND_PL: o_condTrue = ~w_n;
            COND_VS: o_condTrue = w_v;
            COND_VC: o_condTrue = ~w_v;
            COND_HI: o_condTrue = w_c & ~w_z;
            COND_LS: o_condTrue = ~w_c | w_z;
            COND_GE: o_condTrue = (w_n == w_v);
            COND_LT: o_condTrue = (w_n != w_v);
            COND_GT: o_condTrue = ~w_z & (w_n == w_v);
            COND_LE: o_condTrue = w_z | (w_n != w_v);
            COND_NV: o_condTrue = 1'b0;
            default: o_condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry elastic buffer between the ALU output mux and register-file
// writeback. Also owns the architectural status register and evaluates
// branch conditions against it.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int size = 16,
    parameter int m    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_result,
    input  logic [m-1:0]    in_rd,
    input  logic [3:0]      in_flags,
    input  logic            in_set_flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_result,
    output logic [m-1:0]    out_rd,
    output logic [3:0]      flags_n_z_v_c,
    input  logic [3:0]      cond,
    output logic            cond_true,
    output logic [1:0]      count
);

    logic [size-1:0] r_result [2];
    logic [m-1:0]    r_rd     [2];
    logic            r_wrPtr;
    logic            r_rdPtr;
    logic [1:0]      r_count;
    logic [3:0]      r_flags;

    logic w_accept;
    logic w_pop;

    // Ready/valid come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_result    = r_result[r_rdPtr];
    assign out_rd        = r_rd[r_rdPtr];
    assign count         = r_count;
    assign flags_n_z_v_c = r_flags;

    // Storage has no reset; an entry is only observed once count says it is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_result[r_wrPtr] <= in_result;
            r_rd[r_wrPtr]     <= in_rd;
        end
    end

    // Pointers, occupancy and status register; flags follow accepted
    // instructions in program order and ignore pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
            r_flags <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_accept && in_set_flags) begin
                r_flags <= in_flags;
            end
        end
    end

    alu_result_buffer_cond_eval u_condEval (
        .i_flags    (r_flags),
        .i_cond     (cond),
        .o_condTrue (cond_true)
    );

endmodule
